// File: rtl/wb_mon_pkg.sv
// Shared types for the Wishbone B4 protocol monitor: error codes, cycle-type
// encodings and FSM states.
package wb_mon_pkg;

  typedef enum logic [2:0] {
    ERR_NONE       = 3'd0,
    ERR_STB_NO_CYC = 3'd1,
    ERR_ACK_NO_STB = 3'd2,
    ERR_SEL_ZERO   = 3'd3,
    ERR_ADDR_SEQ   = 3'd4,
    ERR_TIMEOUT    = 3'd5,
    ERR_CYC_DROP   = 3'd6,
    ERR_BURST_LEN  = 3'd7
  } err_code_e;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_CONST   = 3'b001;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_BURST = 1'b1
  } state_e;

  // Lowest-numbered violation wins the reported code.
  function automatic err_code_e lowest_code(input logic [7:1] v);
    if (v[1])      return ERR_STB_NO_CYC;
    else if (v[2]) return ERR_ACK_NO_STB;
    else if (v[3]) return ERR_SEL_ZERO;
    else if (v[4]) return ERR_ADDR_SEQ;
    else if (v[5]) return ERR_TIMEOUT;
    else if (v[6]) return ERR_CYC_DROP;
    else if (v[7]) return ERR_BURST_LEN;
    else           return ERR_NONE;
  endfunction

endpackage

// File: rtl/wb_mon_sat_cnt.sv
// Saturating up-counter with synchronous clear (clear has priority).
module wb_mon_sat_cnt #(
  parameter int unsigned W = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i && (cnt_q != '1)) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/wb_protocol_monitor.sv
// Passive Wishbone B4 monitor: burst tracking, stall watchdog, violation
// reporting and saturating read/write beat counters. Never drives the bus.
module wb_protocol_monitor
  import wb_mon_pkg::*;
#(
  parameter int unsigned DW        = 32,
  parameter int unsigned AW        = 26,
  parameter int unsigned TIMEOUT   = 256,
  parameter int unsigned MAX_BURST = 16,
  parameter int unsigned CNT_W     = 32
) (
  input  logic                           sys_clk,
  input  logic                           RESETN,
  input  logic                           wb_cyc_i,
  input  logic                           wb_stb_i,
  input  logic                           wb_we_i,
  input  logic [AW-1:0]                  wb_addr_i,
  input  logic [DW/8-1:0]                wb_sel_i,
  input  logic [2:0]                     wb_cti_i,
  input  logic                           wb_ack_o,
  input  logic                           err_clr_i,
  output logic                           err_pulse,
  output logic [2:0]                     err_code,
  output logic [6:0]                     err_sticky,
  output logic                           burst_active,
  output logic [$clog2(MAX_BURST+1):0]   beat_cnt,
  output logic [CNT_W-1:0]               wr_count,
  output logic [CNT_W-1:0]               rd_count
);

  localparam int unsigned SW  = DW / 8;
  localparam int unsigned BCW = $clog2(MAX_BURST + 1) + 1;
  localparam int unsigned WDW = $clog2(TIMEOUT + 2);
  localparam logic [BCW-1:0] BC_MAX = BCW'(MAX_BURST);
  localparam logic [BCW-1:0] BC_SAT = BCW'(MAX_BURST + 1);
  localparam logic [WDW-1:0] WD_TO  = WDW'(TIMEOUT);

  state_e          state_q;
  logic [BCW-1:0]  beat_cnt_q;
  logic [AW-1:0]   addr_q;
  logic [2:0]      cti_q;
  logic            burst_active_q;
  logic            err_pulse_q;
  err_code_e       err_code_q;
  logic [6:0]      err_sticky_q, err_sticky_d;
  logic [WDW-1:0]  wait_q;
  logic [AW-1:0]   addr_exp;
  logic [7:1]      viol;
  logic            beat, stall, in_burst;

  assign beat     = wb_cyc_i & wb_stb_i & wb_ack_o;
  assign stall    = wb_cyc_i & wb_stb_i & ~wb_ack_o;
  assign in_burst = (state_q == S_BURST);

  wb_mon_sat_cnt #(.W(CNT_W)) u_wr_cnt (
    .clk_i (sys_clk), .rst_ni(RESETN), .clr_i(1'b0),
    .en_i  (beat & wb_we_i), .cnt_o(wr_count)
  );

  wb_mon_sat_cnt #(.W(CNT_W)) u_rd_cnt (
    .clk_i (sys_clk), .rst_ni(RESETN), .clr_i(1'b0),
    .en_i  (beat & ~wb_we_i), .cnt_o(rd_count)
  );

  // Watchdog steps one past TIMEOUT and parks there so the error fires once.
  wb_mon_sat_cnt #(.W(WDW)) u_watchdog (
    .clk_i (sys_clk), .rst_ni(RESETN), .clr_i(~stall),
    .en_i  (stall && (wait_q <= WD_TO)), .cnt_o(wait_q)
  );

  always_comb begin
    addr_exp = (cti_q == CTI_INCR) ? addr_q + AW'(SW) : addr_q;
  end

  // A strobe with no byte lanes is flagged whether or not cyc is asserted.
  always_comb begin
    viol    = '0;
    viol[1] = wb_stb_i & ~wb_cyc_i;
    viol[2] = wb_ack_o & ~(wb_cyc_i & wb_stb_i);
    viol[3] = wb_stb_i & (wb_sel_i == '0);
    viol[4] = in_burst & beat & (wb_addr_i != addr_exp);
    viol[5] = (wait_q == WD_TO);
    viol[6] = in_burst & ~wb_cyc_i;
    viol[7] = in_burst & beat & (beat_cnt_q == BC_MAX);
  end

  always_comb begin
    err_sticky_d = (err_clr_i ? '0 : err_sticky_q) | viol;
  end

  always_ff @(posedge sys_clk or negedge RESETN) begin
    if (!RESETN) begin
      state_q        <= S_IDLE;
      beat_cnt_q     <= '0;
      addr_q         <= '0;
      cti_q          <= CTI_CLASSIC;
      burst_active_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (beat && ((wb_cti_i == CTI_CONST) || (wb_cti_i == CTI_INCR))) begin
            state_q        <= S_BURST;
            burst_active_q <= 1'b1;
            beat_cnt_q     <= BCW'(1);
            addr_q         <= wb_addr_i;
            cti_q          <= wb_cti_i;
          end
        end
        S_BURST: begin
          if (!wb_cyc_i || (beat && (wb_cti_i == CTI_EOB))) begin
            state_q        <= S_IDLE;
            burst_active_q <= 1'b0;
            beat_cnt_q     <= '0;
          end else if (beat) begin
            addr_q <= wb_addr_i;
            if (beat_cnt_q != BC_SAT) beat_cnt_q <= beat_cnt_q + BCW'(1);
          end
        end
        default: begin
          state_q        <= S_IDLE;
          burst_active_q <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge RESETN) begin
    if (!RESETN) begin
      err_pulse_q  <= 1'b0;
      err_code_q   <= ERR_NONE;
      err_sticky_q <= '0;
    end else begin
      err_pulse_q  <= |viol;
      err_code_q   <= lowest_code(viol);
      err_sticky_q <= err_sticky_d;
    end
  end

  assign err_pulse    = err_pulse_q;
  assign err_code     = err_code_q;
  assign err_sticky   = err_sticky_q;
  assign burst_active = burst_active_q;
  assign beat_cnt     = beat_cnt_q;

endmodule
